// File: rtl/irrigation_cycle_ctrl_pkg.sv
// Shared types and constants for the irrigation watering-cycle controller.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WATER,
        SOAK,
        FAULT
    } state_e;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_TANK = 2'b01;
    localparam logic [1:0] FC_DRY  = 2'b10;

endpackage

// File: rtl/irrigation_cycle_ctrl_if.sv
// Signal bundle between the irrigation controller and its environment.
// master: sensors/counter side; slave: the controller.
interface irrigation_cycle_ctrl_if;

    logic [3:0] count;
    logic       dry;
    logic       tank_low;
    logic       ack;
    logic       valve;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] cycle_cnt;

    modport master (
        output count, dry, tank_low, ack,
        input  valve, busy, done, fault, fault_code, cycle_cnt
    );

    modport slave (
        input  count, dry, tank_low, ack,
        output valve, busy, done, fault, fault_code, cycle_cnt
    );

endinterface

// File: rtl/irrigation_cycle_ctrl_tick_delta.sv
// Snapshots the upstream counter on state entry and reports ticks elapsed since.
module tick_delta (
    input  logic       clk,
    input  logic       reset,
    input  logic       snap_en,
    input  logic [3:0] count,
    output logic [3:0] elapsed
);

    logic [3:0] snap_q;

    // Capture the pre-edge count whenever the controller changes state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= 4'd0;
        end else if (snap_en) begin
            snap_q <= count;
        end
    end

    // Modulo-16 subtraction handles counter wrap without special casing.
    assign elapsed = count - snap_q;

endmodule

// File: rtl/irrigation_cycle_ctrl.sv
// Watering-cycle controller: water/soak bursts while soil stays dry, with
// tank-low and retry-exhaustion faults.
module irrigation_cycle_ctrl
    import irrigation_pkg::*;
#(
    parameter int unsigned WATER_TICKS = 10,
    parameter int unsigned SOAK_TICKS  = 5,
    parameter int unsigned MAX_CYCLES  = 3
) (
    input logic                    clk,
    input logic                    reset,
    irrigation_cycle_ctrl_if.slave bus
);

    localparam logic [3:0] WaterTicks = 4'(WATER_TICKS);
    localparam logic [3:0] SoakTicks  = 4'(SOAK_TICKS);
    localparam logic [2:0] MaxCycles  = 3'(MAX_CYCLES);

    state_e     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       snap_en;
    logic [3:0] elapsed;

    tick_delta u_tick_delta (
        .clk     (clk),
        .reset   (reset),
        .snap_en (snap_en),
        .count   (bus.count),
        .elapsed (elapsed)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= FC_NONE;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; tank-low always outranks timer expiry.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.dry && bus.tank_low) begin
                    state_d = FAULT;
                    code_d  = FC_TANK;
                end else if (bus.dry) begin
                    state_d = WATER;
                    cnt_d   = 3'd1;
                    code_d  = FC_NONE;
                end
            end
            WATER: begin
                if (bus.tank_low) begin
                    state_d = FAULT;
                    code_d  = FC_TANK;
                end else if (elapsed == WaterTicks) begin
                    state_d = SOAK;
                end
            end
            SOAK: begin
                if (bus.tank_low) begin
                    state_d = FAULT;
                    code_d  = FC_TANK;
                end else if (elapsed == SoakTicks) begin
                    if (!bus.dry) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (cnt_q < MaxCycles) begin
                        state_d = WATER;
                        cnt_d   = cnt_q + 3'd1;
                    end else begin
                        state_d = FAULT;
                        code_d  = FC_DRY;
                    end
                end
            end
            FAULT: begin
                // Code and burst count stay visible until the next request starts.
                if (bus.ack && !bus.tank_low) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Any state change (including SOAK->WATER re-entry) restarts the timer.
    assign snap_en = (state_d != state_q);

    assign bus.valve      = (state_q == WATER);
    assign bus.busy       = (state_q == WATER) || (state_q == SOAK);
    assign bus.fault      = (state_q == FAULT);
    assign bus.done       = done_q;
    assign bus.fault_code = code_q;
    assign bus.cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_irrigation_cycle_ctrl.sv
// Bench for irrigation_cycle_ctrl: directed scenarios then randomized traffic,
// all outputs compared every cycle against a phase/age reference model.
module tb_irrigation_cycle_ctrl;

    localparam int W = 10;
    localparam int S = 5;
    localparam int M = 3;

    localparam int PhIdle  = 0;
    localparam int PhWater = 1;
    localparam int PhSoak  = 2;
    localparam int PhFault = 3;

    logic clk;
    logic reset;

    irrigation_cycle_ctrl_if bus ();

    irrigation_cycle_ctrl #(
        .WATER_TICKS (W),
        .SOAK_TICKS  (S),
        .MAX_CYCLES  (M)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase plus cycles spent in the phase.
    int m_phase;
    int m_age;
    int m_bursts;
    int m_code;
    bit m_done;

    // Scenario observation counters.
    int       valve_hi;
    int       done_cnt;
    int       fall_count;
    logic     prev_valve;
    logic [3:0] pre_count;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = PhIdle;
        m_age    = 0;
        m_bursts = 0;
        m_code   = 0;
        m_done   = 1'b0;
    endtask

    task automatic model_edge(input bit d, input bit t, input bit a);
        m_done = 1'b0;
        m_age  = m_age + 1;
        case (m_phase)
            PhIdle: begin
                if (d && t) begin
                    m_phase = PhFault; m_code = 1;
                end else if (d) begin
                    m_phase = PhWater; m_age = 0; m_bursts = 1; m_code = 0;
                end
            end
            PhWater: begin
                if (t) begin
                    m_phase = PhFault; m_code = 1;
                end else if (m_age == W) begin
                    m_phase = PhSoak; m_age = 0;
                end
            end
            PhSoak: begin
                if (t) begin
                    m_phase = PhFault; m_code = 1;
                end else if (m_age == S) begin
                    if (!d) begin
                        m_phase = PhIdle; m_done = 1'b1;
                    end else if (m_bursts < M) begin
                        m_phase = PhWater; m_age = 0; m_bursts++;
                    end else begin
                        m_phase = PhFault; m_code = 2;
                    end
                end
            end
            default: begin
                if (a && !t) m_phase = PhIdle;
            end
        endcase
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".valve"}, 8'(bus.valve), 8'(m_phase == PhWater));
        chk({ctx, ".busy"}, 8'(bus.busy), 8'((m_phase == PhWater) || (m_phase == PhSoak)));
        chk({ctx, ".fault"}, 8'(bus.fault), 8'(m_phase == PhFault));
        chk({ctx, ".done"}, 8'(bus.done), 8'(m_done));
        chk({ctx, ".fault_code"}, 8'(bus.fault_code), 8'(m_code));
        chk({ctx, ".cycle_cnt"}, 8'(bus.cycle_cnt), 8'(m_bursts));
    endtask

    // One clock: update model from pre-edge inputs, advance counter, compare.
    task automatic step(input string ctx);
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(bus.dry, bus.tank_low, bus.ack);
        pre_count = bus.count;
        #1;
        bus.count = bus.count + 4'd1;
        check_outputs(ctx);
        if (bus.valve === 1'b1) valve_hi++;
        if (bus.done === 1'b1) done_cnt++;
        if (prev_valve === 1'b1 && bus.valve === 1'b0) fall_count = int'(pre_count);
        prev_valve = bus.valve;
    endtask

    task automatic clear_obs();
        valve_hi   = 0;
        done_cnt   = 0;
        fall_count = -1;
    endtask

    // Advance until the next edge will sample the wanted count (at most 16 cycles).
    task automatic align_to(input logic [3:0] target);
        for (int i = 0; i < 16 && bus.count != target; i++) step("align");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.count    = 4'($urandom_range(0, 15));
        bus.dry      = 1'b0;
        bus.tank_low = 1'b0;
        bus.ack      = 1'b0;
        prev_valve   = 1'b0;
        pre_count    = 4'd0;
        reset        = 1'b1;
        model_reset();
        clear_obs();
        repeat (3) step("reset");
        reset = 1'b0;

        // 1: idle with dry low stays quiet.
        clear_obs();
        repeat (50) step("s1");
        chk("s1_valve_hi", 8'(valve_hi), 8'd0);
        chk("s1_done_cnt", 8'(done_cnt), 8'd0);

        // 2: single burst sampled at count 3.
        align_to(4'd3);
        clear_obs();
        bus.dry = 1'b1;
        step("s2");
        bus.dry = 1'b0;
        repeat (20) step("s2");
        chk("s2_valve_hi", 8'(valve_hi), 8'd10);
        chk("s2_fall_count", 8'(fall_count), 8'd13);
        chk("s2_done_cnt", 8'(done_cnt), 8'd1);
        chk("s2_cycle_cnt", 8'(bus.cycle_cnt), 8'd1);

        // 3: burst spanning counter wrap.
        align_to(4'd12);
        clear_obs();
        bus.dry = 1'b1;
        step("s3");
        bus.dry = 1'b0;
        repeat (20) step("s3");
        chk("s3_valve_hi", 8'(valve_hi), 8'd10);
        chk("s3_fall_count", 8'(fall_count), 8'd6);

        // 4: dry held exhausts the burst limit.
        clear_obs();
        bus.dry = 1'b1;
        repeat (55) step("s4");
        chk("s4_valve_hi", 8'(valve_hi), 8'd30);
        chk("s4_done_cnt", 8'(done_cnt), 8'd0);
        chk("s4_fault", 8'(bus.fault), 8'd1);
        chk("s4_code", 8'(bus.fault_code), 8'd2);
        chk("s4_cycle_cnt", 8'(bus.cycle_cnt), 8'd3);
        chk("s4_valve", 8'(bus.valve), 8'd0);
        bus.dry = 1'b0;
        bus.ack = 1'b1;
        step("s4_ack");
        bus.ack = 1'b0;
        chk("s4_after_ack_fault", 8'(bus.fault), 8'd0);
        chk("s4_held_cycle_cnt", 8'(bus.cycle_cnt), 8'd3);

        // 5: tank low in the 4th water cycle; ack ignored while tank low.
        bus.dry = 1'b1;
        step("s5");
        bus.dry = 1'b0;
        repeat (3) step("s5");
        bus.tank_low = 1'b1;
        step("s5_tank");
        chk("s5_valve", 8'(bus.valve), 8'd0);
        chk("s5_code", 8'(bus.fault_code), 8'd1);
        bus.ack = 1'b1;
        repeat (2) step("s5_ack_low");
        chk("s5_fault_held", 8'(bus.fault), 8'd1);
        bus.tank_low = 1'b0;
        step("s5_ack_ok");
        bus.ack = 1'b0;
        chk("s5_idle_fault", 8'(bus.fault), 8'd0);
        chk("s5_idle_busy", 8'(bus.busy), 8'd0);

        // 6: asynchronous reset mid-water.
        bus.dry = 1'b1;
        step("s6");
        bus.dry = 1'b0;
        repeat (3) step("s6");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("s6_async");
        step("s6_rst");
        reset = 1'b0;
        repeat (2) step("s6_post");
        bus.dry = 1'b1;
        step("s6_restart");
        bus.dry = 1'b0;
        chk("s6_cycle_cnt", 8'(bus.cycle_cnt), 8'd1);
        chk("s6_valve", 8'(bus.valve), 8'd1);

        // Randomized traffic with persistent dry runs and short tank-low events.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) bus.dry = ~bus.dry;
            if (bus.tank_low) bus.tank_low = ($urandom_range(0, 3) != 0);
            else bus.tank_low = ($urandom_range(0, 39) == 0);
            bus.ack = ($urandom_range(0, 4) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
